// File: rtl/sub_div_pkg.sv
// Shared definitions for the repeated-subtraction divider controller.
package sub_div_pkg;

  // Controller state encoding.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Default operand/result width.
  localparam int DEF_WIDTH = 4;

endpackage

// File: rtl/sub_div_ctrl_sub4_flags.sv
// Ripple A-B subtractor (A + ~B + 1) with N/Z/Cout/V flags.
// Cout=1 means no borrow, i.e. A >= B.
module sub4_flags #(
  parameter int WIDTH = sub_div_pkg::DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             n,
  output logic             z,
  output logic             cout,
  output logic             v
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] b_inv;

  assign carry[0] = 1'b1;
  assign b_inv    = ~b;

  // One full-adder cell per bit; carry ripples from LSB upward.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign sum[gi]     = a[gi] ^ b_inv[gi] ^ carry[gi];
      assign carry[gi+1] = (a[gi] & b_inv[gi]) | (carry[gi] & (a[gi] ^ b_inv[gi]));
    end
  endgenerate

  assign cout = carry[WIDTH];
  assign n    = sum[WIDTH-1];
  assign z    = (sum == '0);
  // Signed overflow: operands differ in sign and result sign differs from A.
  assign v    = (a[WIDTH-1] ^ b[WIDTH-1]) & (sum[WIDTH-1] ^ a[WIDTH-1]);

endmodule

// File: rtl/sub_div_ctrl.sv
// Unsigned divider by repeated subtraction through one shared subtractor.
// Each RUN cycle computes R-D and uses Cout/Z to stop, early-exit or continue.
module sub_div_ctrl
  import sub_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] r_reg, r_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic [WIDTH-1:0] d_reg, d_next;
  logic [WIDTH-1:0] quot_reg, quot_next;
  logic [WIDTH-1:0] rem_reg, rem_next;
  logic             dbz_reg, dbz_next;

  logic [WIDTH-1:0] sub_sum;
  logic             sub_z;
  logic             sub_cout;
  logic             sub_n_unused;
  logic             sub_v_unused;

  sub4_flags #(.WIDTH(WIDTH)) u_sub (
    .a    (r_reg),
    .b    (d_reg),
    .sum  (sub_sum),
    .n    (sub_n_unused),
    .z    (sub_z),
    .cout (sub_cout),
    .v    (sub_v_unused)
  );

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      r_reg     <= '0;
      q_reg     <= '0;
      d_reg     <= '0;
      quot_reg  <= '0;
      rem_reg   <= '0;
      dbz_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      r_reg     <= r_next;
      q_reg     <= q_next;
      d_reg     <= d_next;
      quot_reg  <= quot_next;
      rem_reg   <= rem_next;
      dbz_reg   <= dbz_next;
    end
  end

  // Next-state and branch decode from the subtractor's Cout and Z flags.
  always_comb begin
    state_next = state_reg;
    r_next     = r_reg;
    q_next     = q_reg;
    d_next     = d_reg;
    quot_next  = quot_reg;
    rem_next   = rem_reg;
    dbz_next   = dbz_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            // Zero divisor: report immediately, never enter RUN.
            state_next = DONE;
            quot_next  = '1;
            rem_next   = dividend;
            dbz_next   = 1'b1;
          end else begin
            state_next = RUN;
            r_next     = dividend;
            q_next     = '0;
            d_next     = divisor;
          end
        end
      end
      RUN: begin
        if (!sub_cout) begin
          // R < D: the partial remainder is final.
          state_next = DONE;
          quot_next  = q_reg;
          rem_next   = r_reg;
          dbz_next   = 1'b0;
        end else if (sub_z) begin
          // Exact division: finish one step early, which also keeps Q from wrapping.
          state_next = DONE;
          quot_next  = q_reg + ONE;
          rem_next   = '0;
          dbz_next   = 1'b0;
        end else begin
          r_next = sub_sum;
          q_next = q_reg + ONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy        = (state_reg != IDLE);
  assign done        = (state_reg == DONE);
  assign quotient    = quot_reg;
  assign remainder   = rem_reg;
  assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_sub_div_ctrl.sv
// Directed testbench for sub_div_ctrl with hand-computed expectations.
module tb_sub_div_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] dividend = '0;
  logic [3:0] divisor = '0;
  logic       busy, done, div_by_zero;
  logic [3:0] quotient, remainder;

  int tests = 0;
  int fails = 0;

  sub_div_ctrl #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one request and check latency, flags and results.
  // If inj is set, a stray start is pulsed two cycles into RUN.
  task automatic run_div(input logic [3:0] a, input logic [3:0] b,
                         input int exp_k, input logic [3:0] eq,
                         input logic [3:0] er, input logic edbz,
                         input bit inj);
    int done_at;
    done_at = -1;
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    for (int j = 0; j <= 40; j++) begin
      @(negedge clk);
      if (j == 0) begin
        start = 1'b0; dividend = 4'd2; divisor = 4'd1;
      end
      if (inj && j == 2) start = 1'b1;
      if (inj && j == 3) start = 1'b0;
      if (done) begin
        done_at = j;
        break;
      end
      if (j < exp_k) chk("busy_run", {7'd0, busy}, 8'd1);
    end
    chk("latency", done_at[7:0], exp_k[7:0]);
    chk("busy_done", {7'd0, busy}, 8'd1);
    chk("quotient", {4'd0, quotient}, {4'd0, eq});
    chk("remainder", {4'd0, remainder}, {4'd0, er});
    chk("div_by_zero", {7'd0, div_by_zero}, {7'd0, edbz});
    @(negedge clk);
    chk("done_strobe", {7'd0, done}, 8'd0);
    chk("busy_idle", {7'd0, busy}, 8'd0);
    $display("[TB] %0d / %0d -> q=%0d r=%0d dbz=%0b k=%0d", a, b, quotient, remainder,
             div_by_zero, done_at);
  endtask

  initial begin
    // Reset state.
    #2;
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_done", {7'd0, done}, 8'd0);
    chk("rst_q", {4'd0, quotient}, 8'd0);
    chk("rst_r", {4'd0, remainder}, 8'd0);
    chk("rst_dbz", {7'd0, div_by_zero}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_div(4'd7,  4'd2, 4,  4'd3,  4'd1, 1'b0, 1'b0);
    run_div(4'd6,  4'd3, 2,  4'd2,  4'd0, 1'b0, 1'b0);
    run_div(4'd15, 4'd1, 15, 4'd15, 4'd0, 1'b0, 1'b0);
    run_div(4'd3,  4'd5, 1,  4'd0,  4'd3, 1'b0, 1'b0);
    run_div(4'd0,  4'd5, 1,  4'd0,  4'd0, 1'b0, 1'b0);
    run_div(4'd5,  4'd0, 0,  4'hF,  4'd5, 1'b1, 1'b0);
    run_div(4'd9,  4'd4, 3,  4'd2,  4'd1, 1'b0, 1'b0);
    run_div(4'd12, 4'd1, 12, 4'd12, 4'd0, 1'b0, 1'b1);

    // Results hold while idle.
    repeat (3) @(negedge clk);
    chk("hold_q", {4'd0, quotient}, 8'd12);
    chk("hold_r", {4'd0, remainder}, 8'd0);
    chk("hold_busy", {7'd0, busy}, 8'd0);

    // Asynchronous reset in the middle of a long RUN.
    @(negedge clk);
    start = 1'b1; dividend = 4'd15; divisor = 4'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_busy", {7'd0, busy}, 8'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", {7'd0, busy}, 8'd0);
    chk("arst_done", {7'd0, done}, 8'd0);
    chk("arst_q", {4'd0, quotient}, 8'd0);
    chk("arst_r", {4'd0, remainder}, 8'd0);
    chk("arst_dbz", {7'd0, div_by_zero}, 8'd0);
    $display("[TB] reset asserted mid-run");
    @(negedge clk);
    rst_n = 1'b1;
    run_div(4'd8, 4'd3, 3, 4'd2, 4'd2, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
